// File: rtl/bird_if.sv
// Pixel/command bundle between the bird control FSM, the bird datapath and the VGA plotter.
interface bird_if;
  logic [3:0] STATE;
  logic       doneDrawing;
  logic       flying;
  logic [7:0] bird_x;
  logic [6:0] bird_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output STATE,
                  input  doneDrawing, flying, bird_x, bird_y, x, y, colour, plot);
  modport slave  (input  STATE,
                  output doneDrawing, flying, bird_x, bird_y, x, y, colour, plot);
endinterface

// File: rtl/bird_datapath.sv
// One duck: holds position and animation mode, applies FSM commands, and
// rasterises the sprite box one pixel per cycle for erase/redraw passes.
module bird_datapath #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         SPRITE_W    = 8,
  parameter int         SPRITE_H    = 8,
  parameter int         STEP        = 4,
  parameter int         FALL_STEP   = 8,
  parameter int         RISE_STEP   = 8,
  parameter int         SPAWN_X     = 76,
  parameter int         SPAWN_Y     = 56,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [2:0] SHOT_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR   = 3'b011
) (
  input logic  clk,
  input logic  reset,
  bird_if.slave bus
);
  localparam int N    = SPRITE_W * SPRITE_H;
  localparam int CW   = $clog2(N + 1);
  localparam int XMAX = SCREEN_W - SPRITE_W;
  localparam int YMAX = SCREEN_H - SPRITE_H;

  localparam logic [3:0] S_CLEAR = 4'b0001, S_UL   = 4'b0010, S_UR  = 4'b0011;
  localparam logic [3:0] S_DRAW  = 4'b0101, S_DR   = 4'b0110, S_DL  = 4'b0111;
  localparam logic [3:0] S_SHOT  = 4'b1000, S_ESC  = 4'b1001, S_NEW = 4'b1010;

  typedef enum logic [1:0] {M_IDLE, M_FALL, M_RISE} mode_t;

  mode_t          r_mode, w_mode_eff;
  logic [7:0]     r_bx, r_px;
  logic [6:0]     r_by, r_py;
  logic [2:0]     r_colour;
  logic           r_plot, r_done;
  logic [3:0]     r_state_q;
  logic [CW-1:0]  r_cnt, w_cnt, w_col, w_row;
  logic           w_draw, w_flying;

  logic [8:0] w_x_sum;
  logic [7:0] w_y_sum_s, w_y_sum_f;
  logic [7:0] w_x_r, w_x_l;
  logic [6:0] w_y_d, w_y_u, w_y_fall, w_y_rise;

  // A non-IDLE mode is sticky; SHOT/ESCAPE only choose the mode while IDLE.
  always_comb begin
    w_mode_eff = r_mode;
    if (r_mode == M_IDLE) begin
      if (bus.STATE == S_SHOT)     w_mode_eff = M_FALL;
      else if (bus.STATE == S_ESC) w_mode_eff = M_RISE;
    end
  end

  assign w_flying = ((w_mode_eff == M_FALL) && (r_by != 7'(YMAX))) ||
                    ((w_mode_eff == M_RISE) && (r_by != 7'd0));

  always_comb begin
    w_x_sum   = {1'b0, r_bx} + 9'(STEP);
    w_x_r     = (w_x_sum > 9'(XMAX)) ? 8'(XMAX) : w_x_sum[7:0];
    w_x_l     = (r_bx < 8'(STEP)) ? 8'd0 : r_bx - 8'(STEP);
    w_y_sum_s = {1'b0, r_by} + 8'(STEP);
    w_y_d     = (w_y_sum_s > 8'(YMAX)) ? 7'(YMAX) : w_y_sum_s[6:0];
    w_y_u     = (r_by < 7'(STEP)) ? 7'd0 : r_by - 7'(STEP);
    w_y_sum_f = {1'b0, r_by} + 8'(FALL_STEP);
    w_y_fall  = (w_y_sum_f > 8'(YMAX)) ? 7'(YMAX) : w_y_sum_f[6:0];
    w_y_rise  = (r_by < 7'(RISE_STEP)) ? 7'd0 : r_by - 7'(RISE_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bx   <= 8'(SPAWN_X);
      r_by   <= 7'(SPAWN_Y);
      r_mode <= M_IDLE;
    end else begin
      unique case (bus.STATE)
        S_UL: if (r_mode == M_IDLE) begin r_bx <= w_x_l; r_by <= w_y_u; end
        S_UR: if (r_mode == M_IDLE) begin r_bx <= w_x_r; r_by <= w_y_u; end
        S_DL: if (r_mode == M_IDLE) begin r_bx <= w_x_l; r_by <= w_y_d; end
        S_DR: if (r_mode == M_IDLE) begin r_bx <= w_x_r; r_by <= w_y_d; end
        S_SHOT, S_ESC: begin
          r_mode <= w_mode_eff;
          r_by   <= (w_mode_eff == M_FALL) ? w_y_fall : w_y_rise;
        end
        S_NEW: begin
          r_bx   <= 8'(SPAWN_X);
          r_by   <= 7'(SPAWN_Y);
          r_mode <= M_IDLE;
        end
        default: ;
      endcase
    end
  end

  // A change of STATE restarts the raster, so CLEAR->DRAW begins at pixel 0.
  assign w_draw = (bus.STATE == S_CLEAR) || (bus.STATE == S_DRAW);
  assign w_cnt  = (bus.STATE != r_state_q) ? '0 : r_cnt;
  assign w_col  = w_cnt % CW'(SPRITE_W);
  assign w_row  = w_cnt / CW'(SPRITE_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= 4'b0000;
      r_cnt     <= '0;
      r_plot    <= 1'b0;
      r_done    <= 1'b0;
      r_px      <= 8'd0;
      r_py      <= 7'd0;
      r_colour  <= 3'd0;
    end else begin
      r_state_q <= bus.STATE;
      if (!w_draw) begin
        r_cnt  <= '0;
        r_plot <= 1'b0;
        r_done <= 1'b0;
      end else if (w_cnt < CW'(N)) begin
        r_cnt    <= w_cnt + CW'(1);
        r_plot   <= 1'b1;
        r_done   <= 1'b0;
        r_px     <= r_bx + 8'(w_col);
        r_py     <= r_by + 7'(w_row);
        r_colour <= (bus.STATE == S_CLEAR) ? BG_COLOUR :
                    (r_mode == M_FALL)     ? SHOT_COLOUR : BIRD_COLOUR;
      end else begin
        r_cnt  <= w_cnt;
        r_plot <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.doneDrawing = r_done;
  assign bus.flying      = w_flying;
  assign bus.bird_x      = r_bx;
  assign bus.bird_y      = r_by;
  assign bus.x           = r_px;
  assign bus.y           = r_py;
  assign bus.colour      = r_colour;
  assign bus.plot        = r_plot;
endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath: command-vector table plus hand-written draw/reset passes.
module tb_bird_datapath;
  localparam logic [3:0] HOLD = 4'd0, CLEAR = 4'd1, UL = 4'd2, UR = 4'd3;
  localparam logic [3:0] PREHOLD = 4'd4, DRAW = 4'd5, DR = 4'd6, DL = 4'd7;
  localparam logic [3:0] SHOT = 4'd8, ESC = 4'd9, NEW = 4'd10;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  bird_if bus();
  bird_datapath dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       fl;
    int         ex;
    int         ey;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic fl, input int ex, input int ey);
    vec_t v;
    v.st = st; v.fl = fl; v.ex = ex; v.ey = ey;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [3:0] st);
    bus.STATE = st; step(); bus.STATE = HOLD;
  endtask

  // Hold st for ncyc cycles starting now (cycle 0) and check the raster.
  task automatic run_pass(input logic [3:0] st, input int bx, input int by,
                          input logic [2:0] col, input logic fl, input int ncyc);
    int plots = 0;
    bus.STATE = st;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) chk("pass_flying", bus.flying, fl);
      if (c >= 1) begin
        chk("pass_done", bus.doneDrawing, c >= 65);
        chk("pass_plot", bus.plot, (c >= 1) && (c <= 64));
        if (bus.plot === 1'b1) begin
          plots++;
          chk("pass_x", bus.x, bx + (c - 1) % 8);
          chk("pass_y", bus.y, by + (c - 1) / 8);
          chk("pass_colour", bus.colour, col);
        end
      end
      step();
    end
    chk("pass_plot_count", plots, 64);
  endtask

  initial begin
    int plots;
    reset = 1'b1;
    bus.STATE = HOLD;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_bird_x", bus.bird_x, 76);
    chk("rst_bird_y", bus.bird_y, 56);
    chk("rst_plot", bus.plot, 0);
    chk("rst_done", bus.doneDrawing, 0);
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_colour", bus.colour, 0);
    chk("rst_flying", bus.flying, 0);
    step();

    run_pass(DRAW, 76, 56, 3'b110, 1'b0, 70);
    bus.STATE = HOLD; step();
    @(negedge clk);
    chk("leave_done", bus.doneDrawing, 0);
    chk("leave_plot", bus.plot, 0);
    step();

    // Command vectors, starting from spawn (76,56), mode IDLE.
    push(UL, 0, 72, 52); push(UR, 0, 76, 48); push(DL, 0, 72, 52); push(DR, 0, 76, 56);
    push(HOLD, 0, 76, 56); push(PREHOLD, 0, 76, 56);
    push(SHOT, 1, 76, 64); push(UL, 1, 76, 64);
    for (int yy = 72; yy <= 112; yy += 8) push(SHOT, 1, 76, yy);
    push(SHOT, 0, 76, 112); push(ESC, 0, 76, 112); push(HOLD, 0, 76, 112);
    push(NEW, 0, 76, 56); push(HOLD, 0, 76, 56); push(UR, 0, 80, 52);
    push(4'hB, 0, 80, 52); push(4'hF, 0, 80, 52);
    for (int k = 1; k <= 11; k++) push(UL, 0, 80 - 4*k, 52 - 4*k);
    push(ESC, 1, 36, 0); push(ESC, 0, 36, 0); push(SHOT, 0, 36, 0); push(DR, 0, 36, 0);
    push(NEW, 0, 76, 56);
    for (int k = 1; k <= 13; k++) push(UR, 0, 76 + 4*k, 56 - 4*k);
    push(ESC, 1, 128, 0);
    push(NEW, 0, 76, 56);
    for (int k = 1; k <= 20; k++)
      push(UL, 0, (76 - 4*k < 0) ? 0 : 76 - 4*k, (56 - 4*k < 0) ? 0 : 56 - 4*k);
    for (int k = 1; k <= 40; k++)
      push(DR, 0, (4*k > 152) ? 152 : 4*k, (4*k > 112) ? 112 : 4*k);
    push(UL, 0, 148, 108); push(SHOT, 1, 148, 112); push(SHOT, 0, 148, 112);
    push(NEW, 0, 76, 56);

    foreach (vt[i]) begin
      bus.STATE = vt[i].st;
      @(negedge clk);
      chk($sformatf("vec%0d_flying", i), bus.flying, vt[i].fl);
      chk($sformatf("vec%0d_plot", i), bus.plot, 0);
      step();
      chk($sformatf("vec%0d_bird_x", i), bus.bird_x, vt[i].ex);
      chk($sformatf("vec%0d_bird_y", i), bus.bird_y, vt[i].ey);
    end
    bus.STATE = HOLD; step();

    // Shot colour, then direct DRAW->CLEAR, NEW, direct CLEAR->DRAW.
    pulse(SHOT);
    run_pass(DRAW, 76, 64, 3'b100, 1'b1, 70);
    run_pass(CLEAR, 76, 64, 3'b011, 1'b1, 66);
    pulse(NEW);
    run_pass(CLEAR, 76, 56, 3'b011, 1'b0, 66);
    run_pass(DRAW, 76, 56, 3'b110, 1'b0, 66);
    bus.STATE = HOLD; step();
    pulse(UR);
    chk("new_then_ur_x", bus.bird_x, 80);
    chk("new_then_ur_y", bus.bird_y, 52);

    // Reset in cycle 20 of a draw pass.
    bus.STATE = DRAW;
    plots = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.plot === 1'b1) plots++;
      step();
    end
    chk("abort_plots_before", plots, 19);
    reset = 1'b1; step();
    reset = 1'b0; bus.STATE = HOLD;
    @(negedge clk);
    chk("abort_plot", bus.plot, 0);
    chk("abort_done", bus.doneDrawing, 0);
    chk("abort_x", bus.x, 0);
    chk("abort_colour", bus.colour, 0);
    chk("abort_bird_x", bus.bird_x, 76);
    chk("abort_bird_y", bus.bird_y, 56);
    step();
    run_pass(DRAW, 76, 56, 3'b110, 1'b0, 67);
    bus.STATE = HOLD; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
